// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: program counter and instruction-fetch stage.
// Holds the architectural PC, which feeds the external adder.
// Issues one instruction-memory request at a time.
// Hands each fetched word to decode through a valid/ready handshake.
// Branch and jump redirects are honoured in every state.
//
// Ports:
//   Clock, Reset                   clock; asynchronous active-high reset
//   PC            out [31:0]       current PC, drives adder Input1
//   SeqPC         in  [31:0]       adder Soma (PC+4), sequential next PC
//   BranchTaken / BranchTarget     branch redirect (wins over jump)
//   Jump / JumpTarget              jump redirect
//   MemReq, MemAddr   out          one-cycle fetch request and its address
//   MemValid, MemData in           memory response
//   InstValid, Inst, InstPC  out   fetched instruction toward decode
//   InstReady     in               decode accepts the instruction
//   AddrError     out              sticky: a redirect target was misaligned
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] PC,
  input  logic [31:0] SeqPC,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemValid,
  input  logic [31:0] MemData,
  output logic        InstValid,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  input  logic        InstReady,
  output logic        AddrError
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              pend_v_q, pend_v_d;
  logic [XLEN-1:0]   pend_t_q, pend_t_d;
  logic              req_q, req_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic              iv_q, iv_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   ipc_q, ipc_d;
  logic              aerr_q, aerr_d;

  // Redirect decode: branch beats jump; target is forced word-aligned.
  logic              redir;
  logic [XLEN-1:0]   redir_raw;
  logic [XLEN-1:0]   redir_tgt;
  logic              misalign;

  assign redir     = BranchTaken | Jump;
  assign redir_raw = BranchTaken ? BranchTarget : JumpTarget;
  assign redir_tgt = {redir_raw[XLEN-1:2], 2'b00};
  assign misalign  = redir & (redir_raw[1:0] != 2'b00);

  // State and output registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      iv_q     <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      aerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      iv_q     <= iv_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      aerr_q   <= aerr_d;
    end
  end

  // Next-state and output logic. The request pulse is registered, so it is
  // raised on the edge that enters FETCH. Out of reset, FETCH is entered
  // without a pulse, so FETCH first spends one cycle issuing it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    req_d    = 1'b0;
    addr_d   = '0;
    iv_d     = iv_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    aerr_d   = aerr_q | misalign;

    case (state_q)
      S_FETCH: begin
        if (redir) begin
          pend_v_d = 1'b1;
          pend_t_d = redir_tgt;
        end
        if (!req_q) begin
          req_d  = 1'b1;
          addr_d = pc_q;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redir) begin
          pend_v_d = 1'b1;
          pend_t_d = redir_tgt;
        end
        if (MemValid) begin
          if (pend_v_q || redir) begin
            // Response belongs to the abandoned path: drop it and refetch.
            pc_d     = redir ? redir_tgt : pend_t_q;
            pend_v_d = 1'b0;
            state_d  = S_FETCH;
            req_d    = 1'b1;
            addr_d   = pc_d;
          end else begin
            inst_d  = MemData;
            ipc_d   = pc_q;
            iv_d    = 1'b1;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redir) begin
          // Redirect wins over a same-cycle accept; instruction is not consumed.
          iv_d    = 1'b0;
          pc_d    = redir_tgt;
          state_d = S_FETCH;
          req_d   = 1'b1;
          addr_d  = redir_tgt;
        end else if (InstReady) begin
          iv_d    = 1'b0;
          pc_d    = SeqPC;
          state_d = S_FETCH;
          req_d   = 1'b1;
          addr_d  = SeqPC;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign PC        = pc_q;
  assign MemReq    = req_q;
  assign MemAddr   = addr_q;
  assign InstValid = iv_q;
  assign Inst      = inst_q;
  assign InstPC    = ipc_q;
  assign AddrError = aerr_q;

endmodule
